apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
- Shares a single APB master port between N_REQ independent requesters using round-robin arbitration.
- Each requester has a valid/ready command channel and a one-cycle response strobe.
- The block runs the APB SETUP/ACCESS sequence with wait states and a wait-state timeout.
- It sits between test/system agents and the APB slave bus, replacing per-agent task-driven bus access with one synthesizable sequencer.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, PADDR width
- DATA_W, 32, PWDATA/PRDATA width
- TIMEOUT, 16, maximum ACCESS cycles without PREADY before abort; 0 disables the timeout

Ports:
- PCLK  in  1  clock; all logic on the rising edge
- PRESET  in  1  asynchronous reset, active-high
- req_valid  in  N_REQ  command valid, one bit per requester
- req_ready  out  N_REQ  command accepted; one-hot, at most one bit high
- req_write  in  N_REQ  1=write, 0=read, per requester
- req_addr  in  N_REQ*ADDR_W  packed addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  N_REQ*DATA_W  packed write data, sliced the same way
- rsp_valid  out  N_REQ  one-cycle response strobe to the owning requester
- rsp_rdata  out  DATA_W  read data, shared by all requesters; qualified by rsp_valid
- rsp_err  out  1  PSLVERR or timeout; qualified by rsp_valid
- rsp_timeout  out  1  abort caused by timeout; qualified by rsp_valid
- PSEL, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W  APB address
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY, PSLVERR  in  1  APB slave status

Behaviour:
- Reset (async assert, sync release): FSM goes to IDLE, round-robin pointer to 0, wait counter to 0. All outputs are 0: PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout. An in-flight transfer is dropped with no response. After release, requester 0 has highest priority.
- All APB and rsp_* outputs are registered. req_ready is combinational from the FSM state and the grant.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - PSEL=0, PENABLE=0.
  - If any req_valid is high, grant the first requester with req_valid high, searching from ptr upward with wrap-around.
  - Assert req_ready[g] in the same cycle; the handshake completes in that cycle.
  - Latch g, req_write, req_addr and req_wdata; set ptr = (g+1) mod N_REQ; go to SETUP.
  - With no valid request, stay in IDLE; ptr is unchanged.
- SETUP: PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA driven from the latch. Lasts exactly one cycle, then ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; address, control and data held stable.
  - PREADY=1: capture PRDATA (reads only; writes return 0) and PSLVERR, go to RESP. PSLVERR is ignored while PREADY=0.
  - PREADY=0: increment the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with PREADY still 0: go to RESP with err=1, timeout=1, rdata=0.
- RESP:
  - PSEL=0, PENABLE=0.
  - rsp_valid[g]=1 for exactly one cycle, with rsp_rdata, rsp_err and rsp_timeout.
  - Clear the wait counter; go to IDLE.
  - All rsp_* outputs return to 0 the next cycle.
- Zero-wait transfer timing: accept at cycle T, SETUP T+1, ACCESS T+2, rsp_valid at T+3, next accept no earlier than T+4.
- req_valid changes outside IDLE have no effect. A requester holds its command until req_ready; new requests are never queued internally.
- Simultaneous requests resolve strictly by round-robin; no requester is starved beyond N_REQ-1 transfers.
- A requester may re-assert req_valid in the same cycle as its rsp_valid. It is arbitrated in the following IDLE cycle.

Decomposition:
- Package apb_arb_pkg:
  - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_arb_state_t
  - localparam function clog2-based widths for the grant index and wait counter
- Sub-module apb_rr_arbiter (parameter N; inputs req[N], ptr, en; outputs gnt_onehot[N], gnt_idx). Purely combinational; the pointer register lives in the top.

Test Plan:
- Zero-wait write: req0 write addr 0x0000_0010, data 0xA5, PREADY=1 → PSEL at T+1, PENABLE at T+2 with PADDR=0x10 and PWDATA=0xA5; rsp_valid[0] at T+3 with rsp_err=0.
- Read with 3 wait states: req2 read addr 0x40; PREADY low for 3 ACCESS cycles, then PRDATA=0x0000_1234 with PREADY=1 → PENABLE high for 4 cycles, rsp_valid[2] with rsp_rdata=0x1234, rsp_err=0.
- Arbitration: req0..3 all valid continuously after reset → grants 0,1,2,3,0 in that order, each req_ready one-hot.
- Slave error: write to 0x80, PREADY=1 with PSLVERR=1 → rsp_err=1, rsp_timeout=0, bus returns to idle.
- Timeout: TIMEOUT=16, PREADY held 0 → exactly 16 ACCESS cycles, then PSEL/PENABLE drop; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
- Reset mid-ACCESS: assert PRESET during a wait state → all outputs 0 immediately (asynchronous) and no rsp_valid. After release, with req1 and req3 valid, req1 is granted first.

Source files
------------

// File: rtl/apb_req_arbiter_pkg.sv
// Shared types and width helpers for the APB request arbiter.
package apb_arb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_arb_state_t;

    // Index width for a count of n items, never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/apb_req_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, with wrap-around.
module apb_rr_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          en,
    output logic [N-1:0]  gnt_onehot,
    output logic [IW-1:0] gnt_idx
);

    logic [IW:0]   sum;
    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        sum        = '0;
        cand       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            // (ptr + k) mod N without a divider; ptr < N so one subtract suffices
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            cand = sum[IW-1:0];
            if (en && !found && req[cand]) begin
                found            = 1'b1;
                gnt_onehot[cand] = 1'b1;
                gnt_idx          = cand;
            end
        end
    end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin sharing of one APB master port between N_REQ valid/ready requesters,
// with wait-state support and an optional ACCESS-phase timeout.
module apb_req_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_write,
    input  logic [N_REQ*ADDR_W-1:0]  req_addr,
    input  logic [N_REQ*DATA_W-1:0]  req_wdata,
    output logic [N_REQ-1:0]         rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [DATA_W-1:0]        PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR
);

    localparam int unsigned IW = idx_width(N_REQ);
    localparam int unsigned CW = idx_width(TIMEOUT);
    localparam bit          TO_EN = (TIMEOUT != 0);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    apb_arb_state_t    state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     owner;
    logic [CW-1:0]     wait_cnt;
    logic [N_REQ-1:0]  gnt_onehot;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     ptr_next;
    logic              gnt_en;
    logic              timeout_hit;

    logic [ADDR_W-1:0] addr_arr  [N_REQ];
    logic [DATA_W-1:0] wdata_arr [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
        assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
    end

    // Grants only in IDLE and never while reset is asserted.
    assign gnt_en      = (state == IDLE) && !PRESET;
    assign req_ready   = gnt_onehot;
    assign ptr_next    = (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
    assign timeout_hit = TO_EN && (wait_cnt == TO_LAST);

    apb_rr_arbiter #(.N(N_REQ)) u_rr (
        .req        (req_valid),
        .ptr        (ptr),
        .en         (gnt_en),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        owner  <= gnt_idx;
                        ptr    <= ptr_next;
                        PWRITE <= req_write[gnt_idx];
                        PADDR  <= addr_arr[gnt_idx];
                        PWDATA <= wdata_arr[gnt_idx];
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // PREADY wins over a timeout landing in the same cycle
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= N_REQ'(1) << owner;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= RESP;
                    end else if (timeout_hit) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= N_REQ'(1) << owner;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                RESP: begin
                    rsp_valid   <= '0;
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b0;
                    rsp_timeout <= 1'b0;
                    wait_cnt    <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: directed vector table, corner sequences,
// and randomized traffic against a round-robin/latency reference model.
module tb_apb_req_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            PCLK = 1'b0;
    logic            PRESET = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err, rsp_timeout;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA = '0;
    logic            PREADY = 1'b0;
    logic            PSLVERR = 1'b0;

    apb_req_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Slave: fixed mode uses the slv_* knobs; otherwise behaviour is a function of PADDR.
    // PSLVERR carries junk while PREADY is low.
    bit          slv_fixed = 1'b1;
    int          slv_waits = 0;
    bit          slv_err = 1'b0;
    logic [31:0] slv_rdata = '0;
    int          acc_cnt = 0;

    always @(negedge PCLK) begin
        int w;
        if (PSEL && PENABLE) begin
            w       = slv_fixed ? slv_waits : int'(PADDR[4:0]);
            PREADY  = (acc_cnt == w);
            PSLVERR = slv_fixed ? (PREADY ? slv_err : !slv_err) : (PREADY ? PADDR[5] : PADDR[6]);
            PRDATA  = slv_fixed ? slv_rdata : ~PADDR;
            acc_cnt++;
        end else begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = '0;
            acc_cnt = 0;
        end
    end

    typedef struct {
        int          req;
        bit          write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          serr;
        logic [31:0] prdata;
        logic [31:0] exp_rdata;
        bit          exp_err;
        bit          exp_to;
        int          exp_lat;
        int          exp_acc;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [3:0] rr_pick(input logic [3:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (p + k) % N;
            if (v[j]) return 4'(1) << j;
        end
        return 4'b0;
    endfunction

    function automatic int oh_idx(input logic [3:0] v);
        for (int k = 0; k < N; k++) if (v[k]) return k;
        return -1;
    endfunction

    task automatic clear_inputs();
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic do_reset();
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        clear_inputs();
        #1;
        chk("reset_ctl", 64'({PSEL, PENABLE, PWRITE, rsp_err, rsp_timeout, rsp_valid, req_ready}), 64'd0);
        chk("reset_addr", 64'(PADDR), 64'd0);
        chk("reset_data", {PWDATA, rsp_rdata}, 64'd0);
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
    endtask

    task automatic set_cmd(input int r, input bit w, input logic [31:0] a, input logic [31:0] d);
        req_write[r]          = w;
        req_addr[r*AW +: AW]  = a;
        req_wdata[r*DW +: DW] = d;
    endtask

    task automatic run_vec(input vec_t v);
        int lat, acc;
        bit stable, got;
        @(posedge PCLK); #1;
        slv_fixed = 1'b1; slv_waits = v.waits; slv_err = v.serr; slv_rdata = v.prdata;
        set_cmd(v.req, v.write, v.addr, v.wdata);
        req_valid = 4'(1) << v.req;
        @(negedge PCLK);
        chk("accept", 64'(req_ready), 64'(4'(1) << v.req));
        @(posedge PCLK); #1;
        req_valid = '0;
        @(negedge PCLK);
        chk("setup_ctl", 64'({PSEL, PENABLE, PWRITE}), 64'({1'b1, 1'b0, v.write}));
        chk("setup_bus", {PADDR, PWDATA}, {v.addr, v.wdata});
        lat = 1; acc = 0; stable = 1'b1; got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge PCLK);
            lat++;
            if (rsp_valid != 0) got = 1'b1;
            else if (PSEL && PENABLE) begin
                acc++;
                if (PADDR !== v.addr || PWDATA !== v.wdata || PWRITE !== v.write) stable = 1'b0;
            end
        end
        chk("rsp_seen", 64'(got), 64'd1);
        chk("latency", 64'(lat), 64'(v.exp_lat));
        chk("access_cycles", 64'(acc), 64'(v.exp_acc));
        chk("bus_stable", 64'(stable), 64'd1);
        chk("rsp_owner", 64'(rsp_valid), 64'(4'(1) << v.req));
        chk("rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({v.exp_rdata, v.exp_err, v.exp_to}));
        chk("resp_bus_idle", 64'({PSEL, PENABLE}), 64'd0);
        @(negedge PCLK);
        chk("rsp_clear", 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
    endtask

    // Reference model state for the random phase
    bit          m_out;
    int          m_ptr, m_owner, m_due, gi;
    logic [31:0] m_rdata, ra;
    bit          m_err, m_to, busy;
    logic [3:0]  exp_rv, exp_rdy, acc_prev;
    int          grants [5];
    int          gcount;
    bit          seen;

    initial begin
        vecs[0] = '{0, 1'b1, 32'h10,  32'hA5,   0,  1'b0, 32'h0BAD, 32'h0,    1'b0, 1'b0, 3,  1};
        vecs[1] = '{2, 1'b0, 32'h40,  32'h0,    3,  1'b0, 32'h1234, 32'h1234, 1'b0, 1'b0, 6,  4};
        vecs[2] = '{1, 1'b1, 32'h80,  32'h55,   0,  1'b1, 32'h0,    32'h0,    1'b1, 1'b0, 3,  1};
        vecs[3] = '{3, 1'b0, 32'hC0,  32'h0,    20, 1'b0, 32'hDEAD, 32'h0,    1'b1, 1'b1, 18, 16};
        vecs[4] = '{1, 1'b0, 32'h100, 32'h0,    15, 1'b0, 32'hBEEF, 32'hBEEF, 1'b0, 1'b0, 18, 16};
        vecs[5] = '{2, 1'b1, 32'h104, 32'hCAFE, 2,  1'b0, 32'hFFFF, 32'h0,    1'b0, 1'b0, 5,  3};
        vecs[6] = '{0, 1'b0, 32'h200, 32'h0,    0,  1'b1, 32'h77,   32'h77,   1'b1, 1'b0, 3,  1};

        do_reset();
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // All requesters valid continuously from reset: grants must rotate 0,1,2,3,0
        do_reset();
        slv_fixed = 1'b1; slv_waits = 0; slv_err = 1'b0; slv_rdata = '0;
        @(posedge PCLK); #1;
        for (int r = 0; r < N; r++) set_cmd(r, 1'b1, 32'(r * 16), 32'(r));
        req_valid = 4'hF;
        gcount = 0;
        for (int c = 0; c < 40 && gcount < 5; c++) begin
            @(negedge PCLK);
            if (req_ready != 0) begin
                chk("grant_onehot", 64'($onehot(req_ready)), 64'd1);
                grants[gcount] = oh_idx(req_ready);
                gcount++;
            end
        end
        chk("grant_count", 64'(gcount), 64'd5);
        for (int k = 0; k < 5; k++) chk("grant_order", 64'(grants[k]), 64'(k % N));
        @(posedge PCLK); #1;
        req_valid = '0;
        repeat (8) @(negedge PCLK);

        // Reset during a wait state: everything drops at once, no response afterwards
        do_reset();
        slv_fixed = 1'b1; slv_waits = 10; slv_err = 1'b0; slv_rdata = 32'h55;
        @(posedge PCLK); #1;
        set_cmd(0, 1'b0, 32'h300, 32'h0);
        req_valid = 4'b0001;
        @(posedge PCLK); #1;
        req_valid = '0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge PCLK);
            seen = PENABLE;
        end
        chk("mid_access_reached", 64'(seen), 64'd1);
        @(negedge PCLK); #2;
        PRESET = 1'b1;
        set_cmd(1, 1'b1, 32'h400, 32'h11);
        set_cmd(3, 1'b1, 32'h500, 32'h33);
        req_valid = 4'b1010;
        #1;
        chk("async_reset_ctl", 64'({PSEL, PENABLE, PWRITE, rsp_err, rsp_timeout, rsp_valid, req_ready}), 64'd0);
        chk("async_reset_bus", {PADDR, PWDATA}, 64'd0);
        chk("async_reset_rdata", 64'(rsp_rdata), 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge PCLK);
            chk("in_reset_quiet", 64'({rsp_valid, req_ready, PSEL}), 64'd0);
        end
        slv_waits = 0;
        PRESET = 1'b0;
        #1;
        chk("post_reset_grant", 64'(req_ready), 64'b0010);
        @(posedge PCLK); #1;
        req_valid[1] = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge PCLK);
            chk("no_stale_rsp", 64'(rsp_valid[0]), 64'd0);
            seen = (req_ready != 0);
        end
        chk("second_grant", 64'(req_ready), 64'b1000);
        @(posedge PCLK); #1;
        req_valid = '0;
        repeat (8) @(negedge PCLK);

        // Random traffic against the reference model
        do_reset();
        slv_fixed = 1'b0;
        m_out = 1'b0; m_ptr = 0; m_owner = 0; m_due = 0;
        acc_prev = '0;
        for (int c = 0; c < 1500; c++) begin
            @(posedge PCLK); #1;
            for (int r = 0; r < N; r++) begin
                if (acc_prev[r]) req_valid[r] = 1'b0;
                if (!req_valid[r] && c < 1450 && $urandom_range(0, 2) == 0) begin
                    ra = $urandom;
                    ra[4] = ($urandom_range(0, 3) == 0);
                    set_cmd(r, 1'($urandom_range(0, 1)), ra, $urandom);
                    req_valid[r] = 1'b1;
                end
            end
            @(negedge PCLK);
            busy   = m_out && (c <= m_due);
            exp_rv = (m_out && c == m_due) ? 4'(1) << m_owner : 4'b0;
            chk("rnd_rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (m_out && c == m_due) begin
                chk("rnd_rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'({m_rdata, m_err, m_to}));
                m_out = 1'b0;
            end
            exp_rdy = busy ? 4'b0 : rr_pick(req_valid, m_ptr);
            chk("rnd_grant", 64'(req_ready), 64'(exp_rdy));
            if (exp_rdy != 0) begin
                gi      = oh_idx(exp_rdy);
                ra      = req_addr[gi*AW +: AW];
                m_to    = (ra[4:0] >= 5'd16);
                m_err   = m_to || ra[5];
                m_rdata = (m_to || req_write[gi]) ? 32'h0 : ~ra;
                m_due   = c + 3 + (m_to ? 15 : int'(ra[4:0]));
                m_owner = gi;
                m_ptr   = (gi + 1) % N;
                m_out   = 1'b1;
            end
            acc_prev = req_ready;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, got %0d checks expected completion", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
